// File: rtl/serial_cmp.sv
// -----------------------------------------------------------------------------
// serial_cmp
//
// Bit-serial magnitude/equality comparator for two W-bit unsigned words.
// An operand pair is captured on a start/ready handshake, both words are
// scanned MSB-first one bit per clock, and the result (equal / greater /
// less) is reported with a one-cycle done pulse. The per-bit datapath does
// not grow with W; only the two shift registers and the bit counter do.
//
// Handshake: a request is accepted on a rising edge where start=1 and
// ready=1. ready is a pure decode of the state register (high in IDLE
// only) and has no combinational path from start. start while ready=0 is
// ignored, never queued. a/b are only sampled on the accepting edge.
//
// Optional feature (compile-time macro):
//   SERIAL_CMP_EARLY_EXIT_EN - when defined, the scan stops on the first
//   differing bit and goes straight to DONE. Equal operands still take the
//   full W edges. Result values are the same in both builds.
//
// Parameters:
//   W        operand width in bits, legal range 2..64 (default 8)
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   start    in   request, sampled only while ready=1
//   a        in   operand A (W bits, unsigned)
//   b        in   operand B (W bits, unsigned)
//   ready    out  high in IDLE only
//   done     out  one-cycle completion pulse
//   aeqb     out  registered result a == b
//   agtb     out  registered result a > b
//   altb     out  registered result a < b
// -----------------------------------------------------------------------------
module serial_cmp #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         ready,
   output logic         done,
   output logic         aeqb,
   output logic         agtb,
   output logic         altb
);

   // Counter holds W-1 down to 0.
   localparam int CW = (W > 2) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OP   = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q;
   state_t         state_d;

   logic [W-1:0]   sa_q;
   logic [W-1:0]   sb_q;
   logic [CW-1:0]  n_q;
   logic           gt_q;
   logic           lt_q;
   logic           aeqb_q;
   logic           agtb_q;
   logic           altb_q;

   logic           accept;
   logic           bit_gt;
   logic           bit_lt;
   logic           decided;
   logic           gt_nx;
   logic           lt_nx;
   logic           last_bit;
   logic           finish;

   // --------------------------------------------------------------------------
   // Per-bit compare of the current MSBs
   // --------------------------------------------------------------------------
   always_comb begin
      accept   = (state_q == IDLE) && start;
      bit_gt   = sa_q[W-1] & ~sb_q[W-1];
      bit_lt   = ~sa_q[W-1] & sb_q[W-1];
      decided  = gt_q | lt_q;
      // Once a difference has been seen the flags are frozen; lower bits
      // cannot change the ordering of the words.
      gt_nx    = decided ? gt_q : bit_gt;
      lt_nx    = decided ? lt_q : bit_lt;
      last_bit = (n_q == '0);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      // The first differing bit settles the answer, so stop right there.
      finish   = last_bit | (~decided & (bit_gt | bit_lt));
`else
      finish   = last_bit;
`endif
   end

   // --------------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------------------
   // FSM: next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = OP;
            end
         end
         OP: begin
            if (finish) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // Unconditional: a start seen here is ignored, the next accept
            // can only happen from IDLE on the following edge.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // FSM: outputs (decodes of the state register only)
   // --------------------------------------------------------------------------
   always_comb begin
      ready = 1'b0;
      done  = 1'b0;
      case (state_q)
         IDLE:    ready = 1'b1;
         DONE:    done  = 1'b1;
         default: begin
            ready = 1'b0;
            done  = 1'b0;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Datapath: shift registers, bit counter and running flags
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sa_q <= '0;
         sb_q <= '0;
         n_q  <= '0;
         gt_q <= 1'b0;
         lt_q <= 1'b0;
      end else if (accept) begin
         sa_q <= a;
         sb_q <= b;
         n_q  <= CW'(W - 1);
         gt_q <= 1'b0;
         lt_q <= 1'b0;
      end else if (state_q == OP) begin
         sa_q <= {sa_q[W-2:0], 1'b0};
         sb_q <= {sb_q[W-2:0], 1'b0};
         n_q  <= n_q - 1'b1;
         gt_q <= gt_nx;
         lt_q <= lt_nx;
      end
   end

   // --------------------------------------------------------------------------
   // Result registers: loaded only on the edge that enters DONE, so they hold
   // across later accepts until the next completion.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         aeqb_q <= 1'b0;
         agtb_q <= 1'b0;
         altb_q <= 1'b0;
      end else if ((state_q == OP) && finish) begin
         agtb_q <= gt_nx;
         altb_q <= lt_nx;
         aeqb_q <= ~gt_nx & ~lt_nx;
      end
   end

   assign aeqb = aeqb_q;
   assign agtb = agtb_q;
   assign altb = altb_q;

endmodule

// File: tb/tb_serial_cmp.sv
// -----------------------------------------------------------------------------
// tb_serial_cmp
//
// Self-checking bench for serial_cmp (W=8). A behavioural model predicts
// ready/done/results from the operand values and the accept timing alone
// (latency countdown plus an expected-result queue); a compare process
// checks the DUT against it on every falling edge. Directed tests add
// hand-computed latency and result literals. Honours
// SERIAL_CMP_EARLY_EXIT_EN for the expected latencies.
// -----------------------------------------------------------------------------
module tb_serial_cmp;

   localparam int W = 8;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
   localparam int LAT_7F80 = 1;
   localparam int LAT_1020 = 3;
`else
   localparam int LAT_7F80 = 8;
   localparam int LAT_1020 = 8;
`endif

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ready;
   logic         done;
   logic         aeqb;
   logic         agtb;
   logic         altb;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc_q[$];

   // expected result triples {gt, eq, lt}, pushed at accept, popped at done
   logic [2:0] exp_q[$];

   // model state
   bit         m_busy = 1'b0;
   bit         m_done = 1'b0;
   int         m_cnt = 0;
   logic [2:0] m_res = 3'b000;

   serial_cmp #(.W(W)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .ready  (ready),
      .done   (done),
      .aeqb   (aeqb),
      .agtb   (agtb),
      .altb   (altb)
   );

   // ---------------------------------------------------------------- clock
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------- helpers
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // edges from accept to done: W, or first-difference position + 1 when
   // the early-exit build is selected
   function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      for (int i = W - 1; i >= 0; i--) begin
         if (x[i] != y[i]) return W - i;
      end
      return W;
`else
      return W;
`endif
   endfunction

   // ---------------------------------------------------------------- model
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         m_cnt  = 0;
         m_res  = 3'b000;
         exp_q.delete();
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (m_busy) begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            if (exp_q.size() > 0) m_res = exp_q.pop_front();
         end
      end else if (start) begin
         m_busy = 1'b1;
         m_cnt  = exp_lat(a, b);
         exp_q.push_back({a > b, a == b, a < b});
      end
   end

   // ---------------------------------------------------------------- compare
   always @(negedge clk) begin
      chk("ready", ready, !m_busy && !m_done);
      chk("done", done, m_done);
      chk("flags", {agtb, aeqb, altb}, m_res);
      if (done) begin
         done_cnt++;
         done_cyc_q.push_back(cyc);
         chk("onehot", $countones({agtb, aeqb, altb}), 1);
      end
   end

   // ---------------------------------------------------------------- drivers
   task automatic wait_ready(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ready) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk({name, "_ready_timeout"}, 0, 1);
   endtask

   // accept one pair; returns the cycle stamp of the accept edge
   task automatic accept_pair(input logic [W-1:0] xa, input logic [W-1:0] xb, output int t0);
      @(posedge clk);
      #1;
      a = xa;
      b = xb;
      start = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
   endtask

   task automatic wait_done(input string name, output int dcyc);
      bit seen = 1'b0;
      dcyc = -1;
      for (int i = 0; i < 3 * W; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            dcyc = cyc;
            break;
         end
      end
      if (!seen) chk({name, "_done_timeout"}, 0, 1);
   endtask

   task automatic run_one(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic [2:0] exp_flags, input int exp_latency);
      int t0;
      int dcyc;
      wait_ready(name);
      accept_pair(xa, xb, t0);
      wait_done(name, dcyc);
      chk({name, "_latency"}, dcyc - t0, exp_latency);
      chk({name, "_result"}, {agtb, aeqb, altb}, exp_flags);
      @(negedge clk);
      chk({name, "_ready_after"}, ready, 1);
   endtask

   // ---------------------------------------------------------------- tests
   initial begin
      int t0;
      int dcyc;
      int dc0;
      int sz;
      logic [W-1:0] pa[4];
      logic [W-1:0] pb[4];

      reset_n = 1'b0;
      start   = 1'b0;
      a       = '0;
      b       = '0;

      // reset then idle
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("reset_ready", ready, 1);
      chk("reset_done", done, 0);
      chk("reset_flags", {agtb, aeqb, altb}, 3'b000);

      // equal, late difference, early difference
      run_one("eq_a5", 8'hA5, 8'hA5, 3'b010, 8);
      run_one("gt_01", 8'h01, 8'h00, 3'b100, 8);
      run_one("lt_7f", 8'h7F, 8'h80, 3'b001, LAT_7F80);

      // busy start ignored
      wait_ready("busy");
      dc0 = done_cnt;
      accept_pair(8'h10, 8'h20, t0);
      @(posedge clk);
      @(posedge clk);
      #1;
      a = 8'hFF;
      b = 8'h00;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("busy", dcyc);
      chk("busy_latency", dcyc - t0, LAT_1020);
      chk("busy_result", {agtb, aeqb, altb}, 3'b001);
      repeat (2 * W) @(negedge clk);
      chk("busy_single_done", done_cnt - dc0, 1);

      // mid-operation reset
      wait_ready("abort");
      accept_pair(8'hF0, 8'h0F, t0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b0;
      @(negedge clk);
      chk("abort_flags", {agtb, aeqb, altb}, 3'b000);
      chk("abort_done", done, 0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      dc0 = done_cnt;
      @(negedge clk);
      chk("abort_ready", ready, 1);
      repeat (20) @(negedge clk);
      chk("abort_no_done", done_cnt - dc0, 0);
      chk("abort_flags_hold", {agtb, aeqb, altb}, 3'b000);

      // back-to-back with start held high
      pa[0] = 8'h3C; pb[0] = 8'h3C;
      for (int i = 1; i < 4; i++) begin
         pa[i] = W'($urandom_range(0, 255));
         pb[i] = W'($urandom_range(0, 255));
      end
      dc0 = done_cnt;
      @(posedge clk);
      #1;
      a = pa[0];
      b = pb[0];
      start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_ready("b2b");
         @(posedge clk);
         #1;
         if (i < 3) begin
            a = pa[i + 1];
            b = pb[i + 1];
         end else begin
            start = 1'b0;
         end
      end
      for (int i = 0; i < 100 && (done_cnt - dc0) < 4; i++) @(negedge clk);
      chk("b2b_done_count", done_cnt - dc0, 4);
      sz = done_cyc_q.size();
      if (sz >= 4 && (done_cnt - dc0) == 4) begin
         for (int i = 1; i < 4; i++) begin
            chk("b2b_spacing", done_cyc_q[sz - 4 + i] - done_cyc_q[sz - 5 + i],
                exp_lat(pa[i], pb[i]) + 2);
         end
      end
      chk("b2b_last_result", {agtb, aeqb, altb},
          {pa[3] > pb[3], pa[3] == pb[3], pa[3] < pb[3]});

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/serial_cmp.md
# serial_cmp

Bit-serial magnitude/equality comparator for two W-bit unsigned words. It is the sequential, multi-cycle companion to the team's combinational equality comparators, and it trades latency for a per-bit datapath that does not grow with W. It accepts an operand pair on a start/ready handshake and scans the words MSB-first, one bit per clock. It then reports equal / greater / less with a one-cycle done pulse. Typical users are I/O-core register blocks and test benches that compare wide words without a wide comparator.

## Interface
- W, 8, operand width in bits; legal range 2..64.
- clk  in  1  system clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset; deassertion is synchronous to clk at the system level.
- start  in  1  request; sampled only when ready=1.
- a  in  W  operand A, unsigned; captured on the accepting edge.
- b  in  W  operand B, unsigned; captured on the accepting edge.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse; result registers valid from this cycle.
- aeqb  out  1  a == b.
- agtb  out  1  a > b.
- altb  out  1  a < b.

## Operation
- FSM states: IDLE, OP, DONE.
- IDLE:
  - ready=1.
  - On start=1: load shift registers sa<=a and sb<=b, set bit counter n<=W-1, clear running flags gt/lt, go to OP.
- OP:
  - Each edge examines sa[W-1] and sb[W-1], then shifts both left by one.
  - If gt=lt=0: gt<=sa&~sb, lt<=~sa&sb. Once either flag is set, it is frozen.
  - n decrements each edge. At n==0, go to DONE and load result registers: agtb<=gt', altb<=lt', aeqb<=~gt'&~lt', where gt'/lt' include the current bit.
- DONE:
  - done=1 for exactly one cycle, then unconditionally return to IDLE.
- After the first completion, exactly one of aeqb/agtb/altb is 1.
- Results hold until the next completion. A new start does not clear them.
- start while ready=0 is ignored. It is neither queued nor able to corrupt the operation in flight.
- a/b may change freely after the accepting edge.
- reset_n low at any time, including mid-OP:
  - State returns to IDLE, shift registers and flags are cleared.
  - done=0, aeqb=agtb=altb=0.
  - No done pulse is emitted for the aborted operation.

## Timing
- Reset values: ready=1, done=0, aeqb=0, agtb=0, altb=0.
- Accept edge T0 (start=1 and ready=1).
- OP occupies edges T1..TW.
- done=1 in the cycle following TW; the edge that enters DONE is TW.
- Latency from the accept edge to done high: W clock edges. Back to IDLE (ready=1) at TW+1.
- Minimum start-to-start interval: W+2 cycles. start held high continuously is accepted again on the first IDLE cycle.
- ready is a decode of the state register, with no combinational path from start.

## Configuration
- SERIAL_CMP_EARLY_EXIT_EN
  - Defined: in OP, the first edge that sets gt or lt loads the results and goes directly to DONE. Latency becomes k+1 edges, where k = number of leading equal bits (0..W-1). Equal operands still take the full W edges.
  - Undefined: fixed latency of W edges regardless of data.
  - Result values are identical in both builds.

## Test plan
- Reset then idle: assert reset_n=0 for 3 cycles, release -> ready=1, done=0, all three result outputs 0.
- Equal operands, W=8: a=0xA5, b=0xA5 -> done pulses exactly 8 edges after accept; aeqb=1, agtb=0, altb=0; ready=1 on the next cycle.
- Greater/less with late and early difference:
  - a=0x01, b=0x00 -> agtb=1.
  - a=0x7F, b=0x80 -> altb=1.
  - Both complete in 8 edges without the macro. With SERIAL_CMP_EARLY_EXIT_EN, the first takes 8 edges and the second takes 1 edge.
- Busy start ignored: accept a=0x10, b=0x20. Pulse start with a=0xFF, b=0x00 at T3 -> single done with altb=1; no second done follows.
- Mid-operation reset: accept a=0xF0, b=0x0F, drop reset_n at T4 -> outputs 0, ready=1, and no done pulse within 20 cycles after release.
- Back-to-back with start held high: stream of 4 random pairs -> results match a>b / a==b / a<b, with done spacing of W+2 cycles and exactly one result flag high per done.
